// File: rtl/gamma_pkg.sv
// rtl/gamma_pkg.sv - shared constants and FSM encoding for the gamma layer
// Purpose : byte/state widths, FSM state encoding and byte-slice helpers
// Ports   : none (package)
package gamma_pkg;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;
  localparam int STATE_W   = BYTE_W * NUM_BYTES;

  // Byte 0 lives in the most significant byte of the state word.
  localparam int TOP_BYTE_HI = STATE_W - 1;
  localparam int TOP_BYTE_LO = STATE_W - BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gamma_state_e;

endpackage

// File: rtl/gamma_serial_sbox.sv
// rtl/gamma_serial_sbox.sv - 8-bit involutive substitution box
// Purpose : purely combinational table lookup, sbox(sbox(x)) == x
// Ports   : x - byte in
//           y - substituted byte out
module gamma_serial_sbox
  import gamma_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  output logic [BYTE_W-1:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
    8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
    8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
    8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
    8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
    8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
    8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
    8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
    8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
    8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
    8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
    8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
    8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
    8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
    8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
  };

  // Fully populated table: every input has an entry, so no latch is possible.
  assign y = SBOX[x];

endmodule

// File: rtl/gamma_serial.sv
// rtl/gamma_serial.sv - byte-serial gamma (S-box) layer of the cipher round
// Purpose : substitutes all bytes of a state through one shared sbox, one byte/cycle
// Ports   : clk, rst               - clock, async active-high reset
//           in_valid/in_ready/in_data    - upstream state handshake
//           out_valid/out_ready/out_data - downstream state handshake
//           busy                  - high while bytes are being substituted
module gamma_serial
  import gamma_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int CNT_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] out_data,
  output logic                        busy
);

  localparam int SW = BYTE_W * NUM_BYTES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  gamma_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [SW-1:0]     shift_q;
  logic [BYTE_W-1:0] sbox_out;
  logic              load;
  logic              last_byte;

  gamma_serial_sbox u_sbox (
    .x (shift_q[SW-1 -: BYTE_W]),
    .y (sbox_out)
  );

  assign last_byte = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_byte) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // A new state may enter on the same edge the result leaves.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shift_q <= in_data;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        // Substituted byte re-enters at the bottom, so after NUM_BYTES
        // shifts every byte is back in its original position.
        shift_q <= {shift_q[SW-BYTE_W-1:0], sbox_out};
        cnt_q   <= cnt_q + 1'b1;
      end
      if (last_byte) out_data <= {shift_q[SW-BYTE_W-1:0], sbox_out};
    end
  end

endmodule

// File: doc/gamma_serial.md
Name: gamma_serial

Overview:
- Gamma (nonlinear substitution) layer of the 128-bit cipher round.
- Takes a 128-bit state (16 bytes, 4x4 byte matrix, row-major) and applies the 8-bit involutive S-box to every byte.
- Uses a single time-multiplexed sbox instance, one byte per cycle.
- Sits between the round-key-add stage (upstream) and the theta/linear stage (downstream). Both sides use valid/ready handshakes.

Parameters:
- NUM_BYTES, 16, bytes per state; state width is 8*NUM_BYTES.
- CNT_W, 4, byte counter width; must satisfy 2**CNT_W >= NUM_BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream state valid
- in_ready  out  1  block can accept a state this cycle
- in_data  in  8*NUM_BYTES  input state; byte 0 = bits [127:120], byte 15 = bits [7:0]
- out_valid  out  1  substituted state available
- out_ready  in  1  downstream accepts the state
- out_data  out  8*NUM_BYTES  substituted state, same byte order as in_data
- busy  out  1  high while in RUN

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, shift register=0, out_data=0, out_valid=0, busy=0. in_ready=1 once reset is released.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, busy=1.
  - DONE: out_valid=1.
- IDLE -> RUN: on in_valid&&in_ready, capture in_data into the 128-bit shift register and set cnt=0.
- RUN datapath, each cycle:
  - sbox input = shift_reg[127:120].
  - shift_reg <= {shift_reg[119:0], sbox_out}.
  - cnt <= cnt+1.
- RUN -> DONE: on the edge where cnt==NUM_BYTES-1. At that edge out_data <= {shift_reg[119:0], sbox_out}.
- Timing: the handshake at edge E0 is followed by 16 RUN edges. out_valid rises after the 16th RUN edge, i.e. 16 cycles after acceptance.
- DONE -> IDLE: on out_valid&&out_ready with in_valid low.
- DONE -> RUN (back-to-back):
  - In DONE, in_ready = out_ready.
  - If out_ready&&in_valid, capture the new state at the same edge and go to RUN.
  - Steady-state throughput: one state per 17 cycles.
- out_data and out_valid hold stable while out_valid&&!out_ready (no drop, no overwrite). out_data keeps the last result after a drain; it is meaningful only while out_valid=1.
- in_valid is ignored whenever in_ready=0; upstream must hold its data.
- Reset mid-RUN or in DONE: the operation is aborted immediately, all registers return to reset values, and the pending result is discarded.
- S-box sub-module requirements:
  - Purely combinational and total over all 256 inputs (0xFF -> 0x37).
  - Involution: sbox(sbox(x))==x.
  - No latch inferred.

Decomposition:
- Package gamma_pkg holds:
  - localparams BYTE_W=8, NUM_BYTES=16, STATE_W=128;
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - byte-slice helper constants.
- One sub-module: the existing sbox (8-bit in, 8-bit out, combinational), instantiated once.
- The FSM, counter and shift register live in gamma_serial.

Test Plan:
- Zero state: in_data=128'h0 -> 16 cycles later out_valid=1, out_data={16{8'hA7}}.
- Ordered bytes: in_data=128'h000102030405060708090A0B0C0D0E0F -> out_data=128'hA7D3E671D0AC4D793AC991FC1E4754BD.
- Involution and 0xFF coverage:
  - Feed the result of the ordered-bytes test back in -> 128'h000102...0F.
  - in_data={16{8'hFF}} -> {16{8'h37}}.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> new state accepted on the same edge; its result appears 16 cycles later.
- Reset mid-RUN: assert rst after 8 RUN cycles -> out_valid=0 and busy=0 asynchronously, in_ready=1 after release. The next state 128'h0 yields {16{8'hA7}} with no residue from the aborted state.
- Handshake hygiene: toggle in_valid during RUN with garbage data -> ignored, result unaffected, exactly one output per accepted input.
